alarm_controller: RTL

Downstream consumer of the 24-hour digital clock's seconds/minutes/hours outputs. Holds a programmable alarm time, starts ringing when the clock reaches it, and supports snooze, stop and ring timeout. Runs on the same 1 Hz clock as the time counter. Drives the buzzer and the status LEDs.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/alarm_controller_if.sv | 43 ++++
 rtl/alarm_time_reg.sv | 64 ++++++
 rtl/alarm_controller.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day consumers: field widths, range
// limits and the alarm FSM state encoding.
// No ports; imported by the alarm controller files.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CNT_W  = 10;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  typedef enum logic [1:0] {
    ALARM_IDLE    = 2'd0,
    ALARM_RINGING = 2'd1,
    ALARM_SNOOZED = 2'd2
  } alarm_state_e;

  // True when an hours/minutes pair is a legal time of day.
  function automatic logic alarm_time_valid(input logic [HOUR_W-1:0] h,
                                            input logic [MIN_W-1:0]  m);
    return (h <= MAX_HOUR) && (m <= MAX_MIN);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Signal bundle between the time source / user controls and the alarm
// controller.
// master: drives current time, alarm programming and user buttons,
//         receives buzzer/status outputs.
// slave : the alarm controller side.
interface alarm_controller_if;
  import clock_pkg::*;

  // current time
  logic [HOUR_W-1:0] hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  // alarm programming and user controls
  logic              alarm_set;
  logic [HOUR_W-1:0] alarm_hours_in;
  logic [MIN_W-1:0]  alarm_minutes_in;
  logic              alarm_enable;
  logic              snooze;
  logic              stop;
  // status outputs
  logic              buzzer;
  logic              snoozing;
  logic [1:0]        snooze_count;
  logic              missed;
  logic              set_error;
  logic [HOUR_W-1:0] alarm_hours;
  logic [MIN_W-1:0]  alarm_minutes;

  modport master (
    output hours, minutes, seconds, alarm_set, alarm_hours_in,
           alarm_minutes_in, alarm_enable, snooze, stop,
    input  buzzer, snoozing, snooze_count, missed, set_error,
           alarm_hours, alarm_minutes
  );

  modport slave (
    input  hours, minutes, seconds, alarm_set, alarm_hours_in,
           alarm_minutes_in, alarm_enable, snooze, stop,
    output buzzer, snoozing, snooze_count, missed, set_error,
           alarm_hours, alarm_minutes
  );

endinterface

// File: rtl/alarm_time_reg.sv
// Stored alarm time with range-checked loading.
// Ports:
//   Clk_1sec, reset (async, active-high)
//   alarm_set        : load request
//   alarm_hours_in   : requested hours
//   alarm_minutes_in : requested minutes
//   alarm_hours      : stored hours
//   alarm_minutes    : stored minutes
//   set_error        : one-cycle pulse after a rejected load
module alarm_time_reg
  import clock_pkg::*;
(
  input  logic              Clk_1sec,
  input  logic              reset,
  input  logic              alarm_set,
  input  logic [HOUR_W-1:0] alarm_hours_in,
  input  logic [MIN_W-1:0]  alarm_minutes_in,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [MIN_W-1:0]  alarm_minutes,
  output logic              set_error
);

  logic [HOUR_W-1:0] alarm_hours_d,   alarm_hours_q;
  logic [MIN_W-1:0]  alarm_minutes_d, alarm_minutes_q;
  logic              set_error_d,     set_error_q;
  logic              load_ok_s;

  assign load_ok_s = alarm_time_valid(alarm_hours_in, alarm_minutes_in);

  // Next-value logic: an out-of-range pair keeps the old time and flags it.
  always_comb begin
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    set_error_d     = 1'b0;
    if (alarm_set) begin
      if (load_ok_s) begin
        alarm_hours_d   = alarm_hours_in;
        alarm_minutes_d = alarm_minutes_in;
      end else begin
        set_error_d = 1'b1;
      end
    end else begin
      set_error_d = 1'b0;
    end
  end

  // Alarm time and error flag registers.
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      alarm_hours_q   <= 5'd0;
      alarm_minutes_q <= 6'd0;
      set_error_q     <= 1'b0;
    end else begin
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
      set_error_q     <= set_error_d;
    end
  end

  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;
  assign set_error     = set_error_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares the running time with the stored alarm, rings
// the buzzer, handles snooze/stop and times out an unattended ring.
// Ports:
//   Clk_1sec : 1 Hz clock shared with the time counter
//   reset    : asynchronous, active-high
//   bus      : alarm_controller_if.slave (time in, controls in, status out)
// Parameters:
//   RING_SECS   : ring length before auto-timeout (1..1023)
//   SNOOZE_SECS : snooze length before re-ringing (1..1023)
//   MAX_SNOOZE  : snoozes allowed per alarm event (0..3)
module alarm_controller
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
)(
  input  logic               Clk_1sec,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZE);

  alarm_state_e      state_d,        state_q;
  logic [CNT_W-1:0]  counter_d,      counter_q;
  logic [1:0]        snooze_count_d, snooze_count_q;
  logic              missed_d,       missed_q;
  logic              buzzer_d,       buzzer_q;
  logic              snoozing_d,     snoozing_q;
  logic              match_s;
  logic [HOUR_W-1:0] alarm_hours_s;
  logic [MIN_W-1:0]  alarm_minutes_s;

  alarm_time_reg u_time_reg (
    .Clk_1sec         (Clk_1sec),
    .reset            (reset),
    .alarm_set        (bus.alarm_set),
    .alarm_hours_in   (bus.alarm_hours_in),
    .alarm_minutes_in (bus.alarm_minutes_in),
    .alarm_hours      (alarm_hours_s),
    .alarm_minutes    (alarm_minutes_s),
    .set_error        (bus.set_error)
  );

  // Only seconds==0 matches, so a finished event cannot re-fire within the
  // same minute; the next chance is 24 h later.
  assign match_s = (bus.hours == alarm_hours_s) &&
                   (bus.minutes == alarm_minutes_s) &&
                   (bus.seconds == 6'd0);

  // Next-state logic: alarm_set beats alarm_enable=0, which beats the FSM.
  // The counter only ever reaches its current compare value, never wraps.
  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    snooze_count_d = snooze_count_q;
    missed_d       = missed_q;
    if (bus.alarm_set) begin
      state_d        = ALARM_IDLE;
      counter_d      = 10'd0;
      snooze_count_d = 2'd0;
      missed_d       = 1'b0;
    end else if (!bus.alarm_enable) begin
      state_d   = ALARM_IDLE;
      counter_d = 10'd0;
    end else begin
      case (state_q)
        ALARM_IDLE: begin
          if (match_s) begin
            state_d        = ALARM_RINGING;
            counter_d      = 10'd0;
            snooze_count_d = 2'd0;
          end else begin
            counter_d = 10'd0;
          end
        end
        ALARM_RINGING: begin
          // A snooze beyond the limit falls through to the timeout check.
          if (bus.stop) begin
            state_d   = ALARM_IDLE;
            counter_d = 10'd0;
          end else if (bus.snooze && (snooze_count_q < SNOOZE_MAX)) begin
            state_d        = ALARM_SNOOZED;
            snooze_count_d = snooze_count_q + 2'd1;
            counter_d      = 10'd0;
          end else if (counter_q == RING_LAST) begin
            state_d   = ALARM_IDLE;
            counter_d = 10'd0;
            missed_d  = 1'b1;
          end else begin
            counter_d = counter_q + 10'd1;
          end
        end
        ALARM_SNOOZED: begin
          if (bus.stop) begin
            state_d   = ALARM_IDLE;
            counter_d = 10'd0;
          end else if (counter_q == SNOOZE_LAST) begin
            state_d   = ALARM_RINGING;
            counter_d = 10'd0;
          end else begin
            counter_d = counter_q + 10'd1;
          end
        end
        default: begin
          state_d   = ALARM_IDLE;
          counter_d = 10'd0;
        end
      endcase
    end
    // Outputs decoded from the next state so they line up with state_q.
    buzzer_d   = (state_d == ALARM_RINGING);
    snoozing_d = (state_d == ALARM_SNOOZED);
  end

  // FSM, counter and registered status outputs.
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      state_q        <= ALARM_IDLE;
      counter_q      <= 10'd0;
      snooze_count_q <= 2'd0;
      missed_q       <= 1'b0;
      buzzer_q       <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      snooze_count_q <= snooze_count_d;
      missed_q       <= missed_d;
      buzzer_q       <= buzzer_d;
      snoozing_q     <= snoozing_d;
    end
  end

  assign bus.buzzer        = buzzer_q;
  assign bus.snoozing      = snoozing_q;
  assign bus.snooze_count  = snooze_count_q;
  assign bus.missed        = missed_q;
  assign bus.alarm_hours   = alarm_hours_s;
  assign bus.alarm_minutes = alarm_minutes_s;

endmodule
